// File: rtl/and32_slice_sequencer_pkg.sv
// Shared ALU controller definitions: FSM state encoding and slice geometry
// for the time-multiplexed 5-bit logic datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W    = 5;
  localparam int AND_NSLICE = 7;
  localparam int CNT_W      = 3;

endpackage

// File: rtl/and32_slice_sequencer_slice5_and.sv
// 5-bit combinational AND cell, the shared logic slice of the multi-cycle ALU.
module slice5_and (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] y
);

  assign y = a & b;

endmodule

// File: rtl/and32_slice_sequencer.sv
// 32-bit AND built by stepping one 5-bit AND slice over the operand fields.
// Optional zero-result flag output when ZERO_FLAG_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; result holds last completed value
// RUN   | one operand field per cycle through the slice, counter = field index
// DONE  | one-cycle done pulse; start here is accepted like in IDLE
module and32_slice_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_y;

  // Bits of the top field beyond WIDTH never match any i, so they stay zero
  // on the way in and are dropped on the way out.
  always_comb begin
    sl_a   = '0;
    sl_b   = '0;
    acc_nx = acc;
    for (int i = 0; i < WIDTH; i++) begin
      if (i / SLICE == int'(cnt)) begin
        sl_a[i % SLICE] = opa[i];
        sl_b[i % SLICE] = opb[i];
        acc_nx[i]       = sl_y[i % SLICE];
      end
    end
  end

  slice5_and u_slice (
    .a (sl_a),
    .b (sl_b),
    .y (sl_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
`ifdef ZERO_FLAG_EN
      zero   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_nx;
          if (cnt == LAST) begin
            result <= acc_nx;
`ifdef ZERO_FLAG_EN
            zero   <= (acc_nx == '0);
`endif
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and32_slice_sequencer.sv
// Randomized self-checking bench for and32_slice_sequencer against an a&b
// reference with a fixed 7-edge completion latency.
module tb_and32_slice_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
`ifdef ZERO_FLAG_EN
  logic        zero;
`endif

  int n_cmp;
  int n_bad;
  int done_cnt;
  logic [31:0] last_res;

  and32_slice_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef ZERO_FLAG_EN
    ,
    .zero   (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation; operands are scrambled while running, and an optional
  // start pulse with a=0 is injected at run cycle inj (-1 = none).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input int inj, input string tag);
    logic [31:0] exp;
    int          lat;
    bit          got;
    bit          busy_ok;
    bit          hold_ok;
    exp = ta & tbv;
    @(negedge clk);
    a = ta; b = tbv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; got = 0; busy_ok = 1; hold_ok = 1;
    while (!got && lat < 20) begin
      if (done === 1'b1) got = 1;
      else begin
        if (busy !== 1'b1) busy_ok = 0;
        if (result !== last_res) hold_ok = 0;
        a = $urandom; b = $urandom;
        start = (lat == inj);
        if (lat == inj) a = 32'h0;
        @(negedge clk);
        start = 1'b0;
        lat++;
      end
    end
    check({tag, "_timeout"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd7);
    check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    check({tag, "_result"}, result, exp);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
`ifdef ZERO_FLAG_EN
    check({tag, "_zero"}, 32'(zero), 32'(exp == 32'h0));
`endif
    last_res = exp;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    int lat;
    bit got;
    n_cmp = 0; n_bad = 0; done_cnt = 0; last_res = 32'h0;
    start = 1'b0; a = 32'h0; b = 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);
`ifdef ZERO_FLAG_EN
    check("rst_zero", 32'(zero), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, -1, "all_ones");
    run_op(32'hF0F0F0F0, 32'hFF00FF00, -1, "mixed1");
    run_op(32'h12345678, 32'h0F0F0F0F, -1, "mixed2");
    run_op(32'hC0000001, 32'h80000001, -1, "top_slice");

    d0 = done_cnt;
    run_op(32'hFFFF0000, 32'hFFFFFFFF, 3, "start_in_run");
    repeat (12) @(negedge clk);
    check("start_in_run_busy", 32'(busy), 32'd0);
    check("start_in_run_ndone", 32'(done_cnt - d0), 32'd1);

    // Reset while slice 3 is in the accumulator path.
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'h0);
    last_res = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_ndone", 32'(done_cnt - d0), 32'd0);
    run_op(32'h0000001F, 32'h00000011, -1, "after_rst");

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 0) ? ~ra : 32'($urandom);
      run_op(ra, rb, (i % 3 == 0) ? int'($urandom_range(0, 6)) : -1, $sformatf("rnd%0d", i));
    end

    // Back-to-back: start held in the DONE cycle.
    @(negedge clk);
    a = 32'hAAAAAAAA; b = 32'h55555555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      if (done === 1'b1) got = 1;
      else begin @(negedge clk); lat++; end
    end
    check("b2b1_timeout", 32'(got), 32'd1);
    check("b2b1_result", result, 32'h0);
`ifdef ZERO_FLAG_EN
    check("b2b1_zero", 32'(zero), 32'd1);
`endif
    a = 32'h1; b = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    lat = 1; got = 0;
    while (!got && lat < 20) begin
      if (done === 1'b1) got = 1;
      else begin @(negedge clk); lat++; end
    end
    check("b2b2_timeout", 32'(got), 32'd1);
    check("b2b2_spacing", 32'(lat), 32'd8);
    check("b2b2_result", result, 32'h1);
`ifdef ZERO_FLAG_EN
    check("b2b2_zero", 32'(zero), 32'd0);
`endif
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/and32_slice_sequencer.md
Name: and32_slice_sequencer

Overview:
Computes a 32-bit bitwise AND by time-multiplexing one 5-bit AND slice over successive 5-bit fields of the operands. It latches both operands on a start pulse, steps a slice counter, and assembles the result in an accumulator. It presents the result with a one-cycle done pulse. It is the controller that schedules the 5-bit logic datapath inside the multi-cycle ALU.

Parameters:
WIDTH, 32, operand/result width in bits
SLICE, 5, slice width; fixed by the AND cell
NSLICE, (WIDTH+SLICE-1)/SLICE = 7, slice steps per operation (derived, localparam)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled on clk rising edge
a  input  WIDTH  operand A; sampled only on an accepted start
b  input  WIDTH  operand B; sampled only on an accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  final AND result; holds until next completion

Behaviour:
- Reset (async, active-high, immediate): state=IDLE, slice counter=0, operand/accumulator registers=0, busy=0, done=0, result=0. Reset mid-RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches a and b, clears the counter and accumulator, and moves to RUN.
- RUN: busy=1. Each cycle:
  - Feed operand bits [5k+4:5k] (k = counter) into the slice; bits above WIDTH-1 are zero-padded.
  - Write the slice output into accumulator bits [5k+4:5k]; bits above WIDTH-1 are discarded.
  - k=0..5 are full slices. k=6 carries bits [31:30], with slice bits [4:2] padded/dropped.
  - When k=NSLICE-1: copy the completed value into result, set counter=0, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back; next state RUN).
- start while in RUN is ignored; latched operands are unchanged.
- Input changes on a/b outside an accepted start edge have no effect.
- Latency:
  - start sampled at edge E0; slices written at E1..E7; result and done update at E7.
  - done is high in the cycle following E7 (7 cycles after the start edge).
  - Throughput is one operation per 8 cycles; the DONE cycle overlaps the next start.
- result changes only on completion or reset. Partial accumulator contents are never visible on result.

Optional Feature:
Macro ZERO_FLAG_EN.
- Defined: extra output port zero (1 bit), registered together with result. zero=1 iff the completed result==0. Reset value 0.
- Undefined: no zero port and no related logic.

Decomposition:
- Shared package (alu_pkg):
  - State enum: IDLE, RUN, DONE.
  - Constants SLICE_W=5 and AND_NSLICE=7.
  - Slice-counter width localparam: 3 bits.
- One sub-module: slice5_and, the 5-bit combinational AND cell instantiated once. It is the existing team cell and is not re-implemented here.
- Field mux/demux and the FSM stay in the top module.

Test Plan:
- Basic AND: a=32'hFFFFFFFF, b=32'hFFFFFFFF, start 1 cycle -> busy=1 for 7 cycles; then done=1 for 1 cycle with result=32'hFFFFFFFF.
- Mixed fields: a=32'hF0F0F0F0, b=32'hFF00FF00 -> result=32'hF000F000. Separately, a=32'h12345678, b=32'h0F0F0F0F -> result=32'h02040608.
- Partial top slice: a=32'hC0000001, b=32'h80000001 -> result=32'h80000001; no corruption from padded bits.
- start during RUN: operation 1 with a=32'hFFFF0000, b=32'hFFFFFFFF; pulse start at cycle 3 with a=0 -> result=32'hFFFF0000; exactly one done; the second request is not executed.
- Reset mid-run: assert reset during slice 3 -> busy/done/result=0 immediately; no done pulse. After release, a fresh start of a=32'h0000001F, b=32'h00000011 -> result=32'h00000011.
- Back-to-back plus zero flag (ZERO_FLAG_EN defined):
  - Op 1: a=32'hAAAAAAAA, b=32'h55555555 -> result=0, zero=1.
  - start held high in the DONE cycle with a=b=32'h1 -> the next operation completes 8 cycles after the first done with result=1, zero=0.
